// File: rtl/aq_spsram_1024x64_ctrl.sv
// aq_spsram_1024x64_ctrl: access controller for a 1024x64 single-port SRAM.
// One registered access per cycle from a valid/ready requester. Read data
// returns two cycles after acceptance.
// Optional feature macro AQ_SPSRAM_INIT_EN: builds the array-clear engine
// (INIT state, address counter, init_req handling). Without it the
// controller stays in IDLE, init_req is ignored and init_done is 1.
module aq_spsram_1024x64_ctrl #(
   parameter int unsigned           ADDR_WIDTH = 10,
   parameter int unsigned           DATA_WIDTH = 64,
   parameter logic [DATA_WIDTH-1:0] INIT_DATA  = 64'h0
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  init_req,
   input  logic                  req_vld,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_wmask,
   output logic                  req_rdy,
   output logic                  rsp_vld,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   typedef enum logic [0:0] {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_e;

   state_e                state_q;
   logic                  rdy_s;
   logic                  acc_s;
   logic [ADDR_WIDTH-1:0] sram_a_q,    sram_a_d;
   logic                  sram_cen_q,  sram_cen_d;
   logic                  sram_gwen_q, sram_gwen_d;
   logic [DATA_WIDTH-1:0] sram_wen_q,  sram_wen_d;
   logic [DATA_WIDTH-1:0] sram_d_q,    sram_d_d;
   logic                  rsp_vld_q,   rsp_vld_d;
   logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;

`ifdef AQ_SPSRAM_INIT_EN
   state_e                state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

   // FSM state and clear-address counter; reset lands in INIT so the array is cleared first
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q <= ST_INIT;
         cnt_q   <= {ADDR_WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: INIT walks every address once, IDLE leaves only on init_req
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_INIT;
            end
         end
         ST_IDLE: begin
            if (init_req) begin
               state_d = ST_INIT;
               cnt_d   = {ADDR_WIDTH{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = {ADDR_WIDTH{1'b0}};
         end
      endcase
   end

   assign init_done = (state_q == ST_IDLE);
`else
   logic unused_init_s;

   assign state_q       = ST_IDLE;
   assign init_done     = 1'b1;
   assign unused_init_s = init_req ^ (^INIT_DATA);
`endif

   assign rdy_s   = (state_q == ST_IDLE);
   assign acc_s   = req_vld & rdy_s;
   assign req_rdy = rdy_s;

   // Output decode: next-cycle SRAM pin values from the clear engine or the accepted request
   always_comb begin
      sram_a_d    = sram_a_q;
      sram_d_d    = sram_d_q;
      sram_cen_d  = 1'b1;
      sram_gwen_d = 1'b1;
      sram_wen_d  = {DATA_WIDTH{1'b1}};
      case (state_q)
`ifdef AQ_SPSRAM_INIT_EN
         ST_INIT: begin
            sram_a_d    = cnt_q;
            sram_d_d    = INIT_DATA;
            sram_cen_d  = 1'b0;
            sram_gwen_d = 1'b0;
            sram_wen_d  = {DATA_WIDTH{1'b0}};
         end
`endif
         ST_IDLE: begin
            if (acc_s && req_wr) begin
               sram_a_d    = req_addr;
               sram_d_d    = req_wdata;
               sram_cen_d  = 1'b0;
               sram_gwen_d = 1'b0;
               sram_wen_d  = ~req_wmask;
            end else if (acc_s) begin
               sram_a_d    = req_addr;
               sram_cen_d  = 1'b0;
            end else begin
               sram_cen_d  = 1'b1;
            end
         end
         default: begin
            sram_cen_d = 1'b1;
         end
      endcase
   end

   // Response tracking: a read on the pins this cycle has Q valid next cycle
   always_comb begin
      rsp_vld_d = ~sram_cen_q & sram_gwen_q;
      if (rsp_vld_q) begin
         rdata_d = sram_q;
      end else begin
         rdata_d = rdata_q;
      end
   end

   // SRAM pin registers and response registers; reset drops any read in flight
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         sram_a_q    <= {ADDR_WIDTH{1'b0}};
         sram_cen_q  <= 1'b1;
         sram_gwen_q <= 1'b1;
         sram_wen_q  <= {DATA_WIDTH{1'b1}};
         sram_d_q    <= {DATA_WIDTH{1'b0}};
         rsp_vld_q   <= 1'b0;
         rdata_q     <= {DATA_WIDTH{1'b0}};
      end else begin
         sram_a_q    <= sram_a_d;
         sram_cen_q  <= sram_cen_d;
         sram_gwen_q <= sram_gwen_d;
         sram_wen_q  <= sram_wen_d;
         sram_d_q    <= sram_d_d;
         rsp_vld_q   <= rsp_vld_d;
         rdata_q     <= rdata_d;
      end
   end

   // Q is only valid in the response cycle, so it is forwarded straight through
   // then and the captured copy holds it until the next response.
   assign rsp_vld   = rsp_vld_q;
   assign rsp_rdata = rsp_vld_q ? sram_q : rdata_q;
   assign sram_a    = sram_a_q;
   assign sram_cen  = sram_cen_q;
   assign sram_gwen = sram_gwen_q;
   assign sram_wen  = sram_wen_q;
   assign sram_d    = sram_d_q;

endmodule

// File: tb/tb_aq_spsram_1024x64_ctrl.sv
// Testbench for aq_spsram_1024x64_ctrl with a behavioural 1024x64 SRAM.
// Works with and without AQ_SPSRAM_INIT_EN defined.
`timescale 1ns/1ps
module tb_aq_spsram_1024x64_ctrl;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] ZERO = 64'h0;
   localparam logic [63:0] INIT = 64'h0;
`ifdef AQ_SPSRAM_INIT_EN
   localparam logic [63:0] RST_RDY = 64'd0;
`else
   localparam logic [63:0] RST_RDY = 64'd1;
`endif

   logic        clk = 1'b0;
   logic        cpurst_b;
   logic        init_req;
   logic        req_vld;
   logic        req_wr;
   logic [9:0]  req_addr;
   logic [63:0] req_wdata;
   logic [63:0] req_wmask;
   logic        req_rdy;
   logic        rsp_vld;
   logic [63:0] rsp_rdata;
   logic        init_done;
   logic [9:0]  sram_a;
   logic        sram_cen;
   logic        sram_gwen;
   logic [63:0] sram_wen;
   logic [63:0] sram_d;
   logic [63:0] sram_q;
   logic        mem_clr;
   logic [63:0] mem [1024];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   aq_spsram_1024x64_ctrl dut (
      .forever_cpuclk (clk),
      .cpurst_b       (cpurst_b),
      .init_req       (init_req),
      .req_vld        (req_vld),
      .req_wr         (req_wr),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_wmask      (req_wmask),
      .req_rdy        (req_rdy),
      .rsp_vld        (rsp_vld),
      .rsp_rdata      (rsp_rdata),
      .init_done      (init_done),
      .sram_a         (sram_a),
      .sram_cen       (sram_cen),
      .sram_gwen      (sram_gwen),
      .sram_wen       (sram_wen),
      .sram_d         (sram_d),
      .sram_q         (sram_q)
   );

   // Behavioural single-port SRAM: bit-masked write, Q valid the cycle after a read
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 64'h0;
      end else if (!sram_cen) begin
         if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
         else            sram_q <= mem[sram_a];
      end
   end

   typedef struct {
      logic        vld;
      logic        wr;
      logic [9:0]  addr;
      logic [63:0] wdata;
      logic [63:0] wmask;
      logic        e_cen;
      logic        e_gwen;
      logic [63:0] e_wen;
      logic [9:0]  e_a;
      logic [63:0] e_d;
      logic        e_rsp;
      logic [63:0] e_rdata;
   } vec_t;

   localparam int NV = 14;
   vec_t vt [NV];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " cen"},   {63'd0, sram_cen},  64'd1);
      chk({tag, " gwen"},  {63'd0, sram_gwen}, 64'd1);
      chk({tag, " wen"},   sram_wen,           ONES);
      chk({tag, " a"},     {54'd0, sram_a},    ZERO);
      chk({tag, " d"},     sram_d,             ZERO);
      chk({tag, " rsp"},   {63'd0, rsp_vld},   ZERO);
      chk({tag, " rdata"}, rsp_rdata,          ZERO);
      chk({tag, " rdy"},   {63'd0, req_rdy},   RST_RDY);
      chk({tag, " done"},  {63'd0, init_done}, RST_RDY);
   endtask

   task automatic do_read(input logic [9:0] addr, input logic [63:0] exp, input string tag);
      req_vld  = 1'b1;
      req_wr   = 1'b0;
      req_addr = addr;
      step();
      req_vld  = 1'b0;
      step();
      chk({tag, " rsp_vld"}, {63'd0, rsp_vld}, 64'd1);
      chk({tag, " rdata"},   rsp_rdata,        exp);
   endtask

`ifdef AQ_SPSRAM_INIT_EN
   // Walks a full clear from the cycle after reset release or init_req.
   task automatic chk_clear(input string tag);
      int   bad;
      logic done_pre;
      logic done_last;
      bad       = 0;
      done_pre  = 1'b1;
      done_last = 1'b0;
      for (int k = 1; k <= 1024; k++) begin
         step();
         if (sram_a != 10'(k - 1) || sram_cen !== 1'b0 || sram_gwen !== 1'b0 ||
             sram_wen !== ZERO || sram_d !== INIT) bad++;
         if (k < 1024 && (init_done !== 1'b0 || req_rdy !== 1'b0)) bad++;
         if (k == 1023) done_pre = init_done;
         if (k == 1024) done_last = init_done;
      end
      chk({tag, " seq errors"},   64'(bad),            ZERO);
      chk({tag, " done early"},   {63'd0, done_pre},   ZERO);
      chk({tag, " done at end"},  {63'd0, done_last},  64'd1);
      chk({tag, " rdy at end"},   {63'd0, req_rdy},    64'd1);
   endtask
`endif

   initial begin
      int busy_bad;

      //                vld   wr    addr    wdata                  wmask                  cen   gwen  wen                    a       d                      rsp   rdata
      vt[0]  = '{1'b1, 1'b1, 10'h3FF, 64'hDEADBEEF_01234567, ONES,                  1'b0, 1'b0, ZERO,                  10'h3FF, 64'hDEADBEEF_01234567, 1'b0, ZERO};
      vt[1]  = '{1'b1, 1'b0, 10'h3FF, ZERO,                  ZERO,                  1'b0, 1'b1, ONES,                  10'h3FF, 64'hDEADBEEF_01234567, 1'b0, ZERO};
      vt[2]  = '{1'b0, 1'b0, 10'h000, ZERO,                  ZERO,                  1'b1, 1'b1, ONES,                  10'h3FF, 64'hDEADBEEF_01234567, 1'b1, 64'hDEADBEEF_01234567};
      vt[3]  = '{1'b1, 1'b1, 10'h010, ONES,                  64'h0000_0000_FFFF_0000, 1'b0, 1'b0, 64'hFFFF_FFFF_0000_FFFF, 10'h010, ONES,               1'b0, 64'hDEADBEEF_01234567};
      vt[4]  = '{1'b1, 1'b0, 10'h010, ZERO,                  ZERO,                  1'b0, 1'b1, ONES,                  10'h010, ONES,                  1'b0, 64'hDEADBEEF_01234567};
      vt[5]  = '{1'b0, 1'b0, 10'h000, ZERO,                  ZERO,                  1'b1, 1'b1, ONES,                  10'h010, ONES,                  1'b1, 64'h0000_0000_FFFF_0000};
      vt[6]  = '{1'b1, 1'b1, 10'h001, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 10'h001, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0000_0000_FFFF_0000};
      vt[7]  = '{1'b1, 1'b0, 10'h000, ZERO,                  ZERO,                  1'b0, 1'b1, ONES,                  10'h000, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0000_0000_FFFF_0000};
      vt[8]  = '{1'b1, 1'b0, 10'h001, ZERO,                  ZERO,                  1'b0, 1'b1, ONES,                  10'h001, 64'h0123_4567_89AB_CDEF, 1'b1, ZERO};
      vt[9]  = '{1'b1, 1'b1, 10'h001, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0000_0000_0000_00FF, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FF00, 10'h001, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 64'h0123_4567_0000_0000};
      vt[10] = '{1'b1, 1'b0, 10'h001, ZERO,                  ZERO,                  1'b0, 1'b1, ONES,                  10'h001, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 64'h0123_4567_0000_0000};
      vt[11] = '{1'b0, 1'b0, 10'h000, ZERO,                  ZERO,                  1'b1, 1'b1, ONES,                  10'h001, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 64'h0123_4567_0000_00AA};
      vt[12] = '{1'b0, 1'b0, 10'h000, ZERO,                  ZERO,                  1'b1, 1'b1, ONES,                  10'h001, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 64'h0123_4567_0000_00AA};
      vt[13] = '{1'b0, 1'b1, 10'h2AA, 64'h5555_5555_5555_5555, ONES,                  1'b1, 1'b1, ONES,                  10'h001, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 64'h0123_4567_0000_00AA};

      cpurst_b  = 1'b0;
      mem_clr   = 1'b1;
      init_req  = 1'b0;
      req_vld   = 1'b0;
      req_wr    = 1'b0;
      req_addr  = 10'h0;
      req_wdata = ZERO;
      req_wmask = ZERO;
      repeat (3) step();
      chk_reset_vals("reset");
      mem_clr  = 1'b0;
      cpurst_b = 1'b1;

`ifdef AQ_SPSRAM_INIT_EN
      // Release cycle counts as cycle 1: clear writes 0..1023, IDLE at cycle 1025.
      chk_clear("init");
`endif

      // Table-driven accesses: inputs in cycle k, pins checked in k+1
      for (int i = 0; i < NV; i++) begin
         req_vld   = vt[i].vld;
         req_wr    = vt[i].wr;
         req_addr  = vt[i].addr;
         req_wdata = vt[i].wdata;
         req_wmask = vt[i].wmask;
         step();
         chk($sformatf("row%0d cen", i),   {63'd0, sram_cen},  {63'd0, vt[i].e_cen});
         chk($sformatf("row%0d gwen", i),  {63'd0, sram_gwen}, {63'd0, vt[i].e_gwen});
         chk($sformatf("row%0d wen", i),   sram_wen,           vt[i].e_wen);
         chk($sformatf("row%0d a", i),     {54'd0, sram_a},    {54'd0, vt[i].e_a});
         chk($sformatf("row%0d d", i),     sram_d,             vt[i].e_d);
         chk($sformatf("row%0d rsp", i),   {63'd0, rsp_vld},   {63'd0, vt[i].e_rsp});
         chk($sformatf("row%0d rdata", i), rsp_rdata,          vt[i].e_rdata);
         chk($sformatf("row%0d rdy", i),   {63'd0, req_rdy},   64'd1);
      end
      req_vld = 1'b0;
      req_wr  = 1'b0;

      // init_req coincident with a read of address 5
      req_vld  = 1'b1;
      req_wr   = 1'b0;
      req_addr = 10'h005;
      init_req = 1'b1;
      step();
      req_vld  = 1'b0;
      init_req = 1'b0;
      chk("coinc read cen",  {63'd0, sram_cen},  ZERO);
      chk("coinc read gwen", {63'd0, sram_gwen}, 64'd1);
      chk("coinc read a",    {54'd0, sram_a},    64'h005);
      busy_bad = (req_rdy !== RST_RDY[0]) ? 1 : 0;
      step();
      chk("coinc rsp_vld", {63'd0, rsp_vld}, 64'd1);
      chk("coinc rdata",   rsp_rdata,        INIT);
`ifdef AQ_SPSRAM_INIT_EN
      chk("coinc clear a0",  {54'd0, sram_a},    ZERO);
      chk("coinc clear cen", {63'd0, sram_cen},  ZERO);
      // busy over cycles N+1..N+1024, ready again at N+1025
      for (int k = 2; k <= 1024; k++) begin
         if (req_rdy !== 1'b0) busy_bad++;
         step();
      end
      chk("coinc busy cycles", 64'(busy_bad),     ZERO);
      chk("coinc rdy after",   {63'd0, req_rdy},  64'd1);
      chk("coinc done after",  {63'd0, init_done}, 64'd1);
      do_read(10'h3FF, INIT, "clr 3ff");
      do_read(10'h010, INIT, "clr 010");
      do_read(10'h001, INIT, "clr 001");
      do_read(10'h005, INIT, "clr 005");
`else
      chk("coinc ignored rdy",  64'(busy_bad),      ZERO);
      chk("coinc ignored done", {63'd0, init_done}, 64'd1);
      do_read(10'h3FF, 64'hDEADBEEF_01234567, "keep 3ff");
      do_read(10'h010, 64'h0000_0000_FFFF_0000, "keep 010");
      do_read(10'h001, 64'h0123_4567_0000_00AA, "keep 001");
`endif

`ifdef AQ_SPSRAM_INIT_EN
      // Reset mid-clear with the counter at 500, then clear restarts from 0
      init_req = 1'b1;
      step();
      init_req = 1'b0;
      repeat (500) step();
      chk("pre-reset clear a", {54'd0, sram_a}, 64'd499);
      cpurst_b = 1'b0;
      #1;
      chk_reset_vals("midclr reset");
      step();
      cpurst_b = 1'b1;
      chk_clear("restart");
`else
      // Reset with a read in flight: the response is dropped
      req_vld  = 1'b1;
      req_wr   = 1'b0;
      req_addr = 10'h155;
      step();
      req_vld  = 1'b0;
      chk("inflight cen", {63'd0, sram_cen}, ZERO);
      cpurst_b = 1'b0;
      #1;
      chk_reset_vals("inflight reset");
      step();
      cpurst_b = 1'b1;
      step();
      chk("inflight dropped", {63'd0, rsp_vld}, ZERO);
      step();
      chk("inflight dropped2", {63'd0, rsp_vld}, ZERO);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aq_spsram_1024x64_ctrl.md
AQ_SPSRAM_1024X64_CTRL -- requirements
Module: aq_spsram_1024x64_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, SRAM address width (fixed, 1024 entries).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, SRAM data and bit-mask width.
REQ-003 SHALL have parameter INIT_DATA, default 64'h0, pattern written to every entry during clear.
REQ-004 SHALL have port forever_cpuclk, input, 1, the single clock; all state is on its rising edge.
REQ-005 SHALL have port cpurst_b, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port init_req, input, 1, single-cycle pulse requesting a full-array clear.
REQ-007 SHALL have port req_vld, input, 1, requester access valid.
REQ-008 SHALL have port req_wr, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, 10, entry index.
REQ-010 SHALL have port req_wdata, input, 64, write data.
REQ-011 SHALL have port req_wmask, input, 64, active-high per-bit write enable.
REQ-012 SHALL have port req_rdy, output, 1, controller accepts the request this cycle.
REQ-013 SHALL have port rsp_vld, output, 1, read data valid, one-cycle pulse.
REQ-014 SHALL have port rsp_rdata, output, 64, read data, held until the next rsp_vld.
REQ-015 SHALL have port init_done, output, 1, array clear complete, controller in IDLE.
REQ-016 SHALL have ports sram_a (output, 10), sram_cen (output, 1, active-low chip enable), sram_gwen (output, 1, active-low global write enable), sram_wen (output, 64, active-low bit write enable), sram_d (output, 64), sram_q (input, 64), all connecting to a 1024x64 single-port SRAM whose Q is valid the cycle after a read access.

Function
REQ-017 SHALL implement FSM states INIT and IDLE.
REQ-018 SHALL accept a request when req_vld && req_rdy; req_rdy SHALL equal (state == IDLE), giving one access per cycle.
REQ-019 SHALL register all sram_* outputs; a request accepted in cycle N SHALL appear on the SRAM pins in cycle N+1.
REQ-020 For an accepted write, in N+1: sram_cen=0, sram_gwen=0, sram_wen=~req_wmask, sram_d=req_wdata, sram_a=req_addr; no response is generated.
REQ-021 For an accepted read, in N+1: sram_cen=0, sram_gwen=1, sram_wen=all ones, sram_a=req_addr; in N+2, rsp_vld=1 and rsp_rdata SHALL be loaded from sram_q.
REQ-022 With no accepted request and state IDLE, the next cycle SHALL drive sram_cen=1, sram_gwen=1, sram_wen=all ones; sram_a and sram_d SHALL hold their values.
REQ-023 In INIT, a 10-bit counter SHALL drive one write per cycle: sram_a=counter, sram_d=INIT_DATA, sram_wen=0, sram_gwen=0, sram_cen=0, counter increments from 0 to 1023.
REQ-024 When the write at address 1023 is issued, the counter SHALL wrap to 0 and the FSM SHALL enter IDLE next cycle, with init_done=1 and req_rdy=1 in that cycle.
REQ-025 init_req in IDLE SHALL move the FSM to INIT next cycle, clear init_done, and zero the counter; init_req in INIT SHALL be ignored.
REQ-026 If init_req and an accepted request coincide in IDLE, the request SHALL complete normally (read response still at N+2), and the clear SHALL begin in N+1.
REQ-027 Read-after-write to the same address in consecutive cycles SHALL return the written data.

Reset
REQ-028 On cpurst_b=0: sram_cen=1, sram_gwen=1, sram_wen=all ones, sram_a=0, sram_d=0, rsp_vld=0, rsp_rdata=0, counter=0; in-flight reads are discarded.
REQ-029 Reset state SHALL be INIT (init_done=0, req_rdy=0) when AQ_SPSRAM_INIT_EN is defined, else IDLE (init_done=1, req_rdy=1).

Configuration
REQ-030 Macro AQ_SPSRAM_INIT_EN SHALL include the INIT state, counter and init_req handling; when it is undefined, INIT logic SHALL be removed, init_req SHALL be ignored, and init_done SHALL be constant 1.

Verification
REQ-031 Macro defined, release reset -> 1024 consecutive writes of INIT_DATA to addresses 0..1023, then init_done=1 at cycle 1025 after release.
REQ-032 Write addr 0x3FF data 0xDEADBEEF_01234567 mask all ones, then read 0x3FF -> rsp_vld two cycles after read acceptance, rsp_rdata=0xDEADBEEF_01234567.
REQ-033 Write mask 0x0000_0000_FFFF_0000 over a cleared entry -> sram_wen=0xFFFF_FFFF_0000_FFFF, and readback shows only bits 31:16 changed.
REQ-034 init_req coincident with a read of addr 5 -> rsp_vld delivered, req_rdy=0 for the next 1024 cycles, all entries read INIT_DATA afterwards.
REQ-035 Assert cpurst_b=0 mid-clear at counter 500 -> all outputs reach reset values immediately; after release, the clear restarts at address 0.
